// File: rtl/day_night_fader.sv
// Day/night palette fader on the VGA pixel path: score-triggered fade to a
// darkened palette, a score-length night hold, then a fade back to day.
module day_night_fader #(
    parameter int unsigned CW       = 4,
    parameter int unsigned SCORE_W  = 14,
    parameter int unsigned PERIOD   = 700,
    parameter int unsigned DARK_LEN = 150,
    parameter int unsigned TICK_W   = 23,
    parameter int unsigned MODE     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid,
    input  logic [SCORE_W-1:0] game_score,
    input  logic [CW-1:0]      in_r,
    input  logic [CW-1:0]      in_g,
    input  logic [CW-1:0]      in_b,
    output logic [CW-1:0]      out_r,
    output logic [CW-1:0]      out_g,
    output logic [CW-1:0]      out_b,
    output logic               is_dark,
    output logic               fading
);

    typedef enum logic [1:0] {
        LIGHT,
        FADE_DARK,
        DARK,
        FADE_LIGHT
    } state_t;

    localparam logic [CW-1:0]      LVL_MAX    = '1;
    localparam logic [SCORE_W-1:0] PERIOD_S   = SCORE_W'(PERIOD);
    localparam logic [SCORE_W:0]   DARK_LEN_S = (SCORE_W + 1)'(DARK_LEN);

    state_t               state_q, state_d;
    logic [CW-1:0]        level_q, level_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [SCORE_W-1:0]   start_score_q, start_score_d;
    logic [SCORE_W-1:0]   last_score_q, last_score_d;
    logic [CW-1:0]        out_r_q, out_r_d;
    logic [CW-1:0]        out_g_q, out_g_d;
    logic [CW-1:0]        out_b_q, out_b_d;
    logic                 is_dark_q, is_dark_d;
    logic                 fading_q, fading_d;

    logic                 tick;
    logic                 trig;
    logic                 rst_game;
    logic                 dark_done;
    logic [SCORE_W:0]     score_diff;

    function automatic logic [CW-1:0] fade_px(input logic [CW-1:0] c,
                                              input logic [CW-1:0] lvl);
        logic [CW-1:0] r;
        if (MODE == 0) begin
            r = (c >= lvl) ? c - lvl : lvl - c;
        end else begin
            r = (c > lvl) ? c - lvl : '0;
        end
        return r;
    endfunction

    // Extra top bit keeps the difference from wrapping; a set MSB means the
    // score is below start_score, which never counts as the end of night.
    always_comb begin
        tick       = (tick_cnt_q == '1);
        trig       = (game_score != last_score_q) &&
                     ((game_score % PERIOD_S) == '0) &&
                     (game_score != '0);
        rst_game   = (game_score < last_score_q);
        score_diff = {1'b0, game_score} - {1'b0, start_score_q};
        dark_done  = !score_diff[SCORE_W] && (score_diff >= DARK_LEN_S);
    end

    always_comb begin
        tick_cnt_d    = tick_cnt_q + 1'b1;
        last_score_d  = game_score;
        state_d       = state_q;
        level_d       = level_q;
        start_score_d = start_score_q;

        if (rst_game) begin
            state_d = (level_q == '0) ? LIGHT : FADE_LIGHT;
        end else if (trig) begin
            start_score_d = game_score;
            state_d       = (level_q == LVL_MAX) ? DARK : FADE_DARK;
        end else begin
            case (state_q)
                LIGHT: begin
                    level_d = '0;
                end
                FADE_DARK: begin
                    if (dark_done) begin
                        state_d = (level_q == '0) ? LIGHT : FADE_LIGHT;
                    end else if (tick) begin
                        if (level_q != LVL_MAX) level_d = level_q + 1'b1;
                        if (level_d == LVL_MAX) state_d = DARK;
                    end
                end
                DARK: begin
                    if (dark_done) state_d = FADE_LIGHT;
                end
                FADE_LIGHT: begin
                    if (tick && level_q != '0) level_d = level_q - 1'b1;
                    if (level_d == '0) state_d = LIGHT;
                end
                default: state_d = LIGHT;
            endcase
        end

        is_dark_d = (state_d == FADE_DARK) || (state_d == DARK);
        fading_d  = (state_d == FADE_DARK) || (state_d == FADE_LIGHT);

        // Pixel transform uses the level as it stood before this edge.
        out_r_d = valid ? fade_px(in_r, level_q) : '0;
        out_g_d = valid ? fade_px(in_g, level_q) : '0;
        out_b_d = valid ? fade_px(in_b, level_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= LIGHT;
            level_q       <= '0;
            tick_cnt_q    <= '0;
            start_score_q <= '0;
            last_score_q  <= '0;
            out_r_q       <= '0;
            out_g_q       <= '0;
            out_b_q       <= '0;
            is_dark_q     <= 1'b0;
            fading_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            tick_cnt_q    <= tick_cnt_d;
            start_score_q <= start_score_d;
            last_score_q  <= last_score_d;
            out_r_q       <= out_r_d;
            out_g_q       <= out_g_d;
            out_b_q       <= out_b_d;
            is_dark_q     <= is_dark_d;
            fading_q      <= fading_d;
        end
    end

    assign out_r   = out_r_q;
    assign out_g   = out_g_q;
    assign out_b   = out_b_q;
    assign is_dark = is_dark_q;
    assign fading  = fading_q;

endmodule

// File: tb/tb_day_night_fader.sv
// Directed bench for day_night_fader: two instances (MODE 0 and MODE 1) with
// TICK_W=2 share one stimulus stream; expected values are hand-computed.
module tb_day_night_fader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [13:0] game_score;
    logic [3:0]  in_r, in_g, in_b;
    logic [3:0]  r0, g0, b0, r1, g1, b1;
    logic        dark0, fade0, dark1, fade1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;

    day_night_fader #(.TICK_W(2), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .game_score(game_score),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_r(r0), .out_g(g0), .out_b(b0), .is_dark(dark0), .fading(fade0)
    );

    day_night_fader #(.TICK_W(2), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .game_score(game_score),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_r(r1), .out_g(g1), .out_b(b1), .is_dark(dark1), .fading(fade1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Edge counter tracks edges since reset release; tick fires at edges with cyc%4==0.
    task automatic run_to(input int unsigned edge_n, input logic [13:0] score);
        while (cyc < edge_n) begin
            game_score = score;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic logic [11:0] px0();
        return {r0, g0, b0};
    endfunction

    function automatic logic [11:0] px1();
        return {r1, g1, b1};
    endfunction

    function automatic logic [1:0] st0();
        return {dark0, fade0};
    endfunction

    initial begin
        rst_n      = 1'b0;
        valid      = 1'b1;
        game_score = '0;
        in_r = 4'd5; in_g = 4'd9; in_b = 4'd15;

        @(posedge clk); #1;
        check("reset_px", 32'(px0()), 32'h000);
        @(posedge clk); #1;
        check("reset_px1", 32'(px1()), 32'h000);
        check("reset_st", 32'(st0()), 32'h0);
        rst_n = 1'b1;

        // Idle: scores 0..699, palette passes through unchanged
        for (int s = 0; s < 700; s++) begin
            run_to(s + 1, 14'(s));
            check("idle_px", 32'(px0()), 32'h59F);
            check("idle_st", 32'(st0()), 32'h0);
        end
        check("idle_px1", 32'(px1()), 32'h59F);

        // Trigger at 700, fade to night
        run_to(701, 14'd700);
        check("trig_st", 32'(st0()), 32'h3);
        check("trig_px_lvl0", 32'(px0()), 32'h59F);
        run_to(705, 14'd700);
        check("lvl1_px", 32'(px0()), 32'h48E);
        run_to(732, 14'd700);
        in_r = 4'd3; in_g = 4'd12; in_b = 4'd15;
        run_to(733, 14'd700);
        check("lvl8_mode1", 32'(px1()), 32'h047);
        check("lvl8_mode0", 32'(px0()), 32'h547);
        valid = 1'b0;
        run_to(734, 14'd700);
        check("invalid_px0", 32'(px0()), 32'h000);
        check("invalid_px1", 32'(px1()), 32'h000);
        valid = 1'b1;
        in_r = 4'd5; in_g = 4'd9; in_b = 4'd15;
        run_to(759, 14'd700);
        check("fade_dark_st", 32'(st0()), 32'h3);
        run_to(760, 14'd700);
        check("dark_reached", 32'(st0()), 32'h2);
        check("dark_reached1", 32'({dark1, fade1}), 32'h2);
        check("lvl14_px", 32'(px0()), 32'h951);
        run_to(764, 14'd700);
        check("lvl15_px", 32'(px0()), 32'hA60);
        check("lvl15_px1", 32'(px1()), 32'h000);

        // Night hold 700..849, then 850 ends it
        for (int s = 701; s < 850; s++) run_to(s + 64, 14'(s));
        check("hold_849", 32'(st0()), 32'h2);
        run_to(914, 14'd850);
        check("dark_done_st", 32'(st0()), 32'h1);
        run_to(917, 14'd850);
        check("fade_light_px", 32'(px0()), 32'h951);
        run_to(971, 14'd850);
        check("fade_light_st", 32'(st0()), 32'h1);
        run_to(972, 14'd850);
        check("light_reached", 32'(st0()), 32'h0);
        run_to(976, 14'd850);
        check("light_px", 32'(px0()), 32'h59F);

        // Held multiple of PERIOD, then a skipped score ends the night
        run_to(977, 14'd1400);
        check("trig1400_st", 32'(st0()), 32'h3);
        run_to(1035, 14'd1400);
        check("fd1400_st", 32'(st0()), 32'h3);
        run_to(1036, 14'd1400);
        check("dark1400_st", 32'(st0()), 32'h2);
        run_to(1076, 14'd1400);
        check("held1400_st", 32'(st0()), 32'h2);
        run_to(1077, 14'd1600);
        check("skip_done_st", 32'(st0()), 32'h1);
        run_to(1135, 14'd1600);
        check("skip_fl_st", 32'(st0()), 32'h1);
        run_to(1136, 14'd1600);
        check("skip_light_st", 32'(st0()), 32'h0);

        // Restart while dark
        run_to(1141, 14'd2100);
        check("trig2100_st", 32'(st0()), 32'h3);
        run_to(1200, 14'd2100);
        check("dark2100_st", 32'(st0()), 32'h2);
        run_to(1204, 14'd2160);
        check("dark2160_st", 32'(st0()), 32'h2);
        run_to(1205, 14'd0);
        check("restart_st", 32'(st0()), 32'h1);
        run_to(1210, 14'd0);
        check("no_retrig_st", 32'(st0()), 32'h1);
        run_to(1263, 14'd0);
        check("restart_fl_st", 32'(st0()), 32'h1);
        run_to(1264, 14'd0);
        check("restart_light", 32'(st0()), 32'h0);
        run_to(1265, 14'd0);
        check("restart_px", 32'(px0()), 32'h59F);

        // Reset mid-fade
        run_to(1266, 14'd700);
        check("trig_again_st", 32'(st0()), 32'h3);
        run_to(1275, 14'd700);
        rst_n      = 1'b0;
        game_score = 14'd0;
        @(posedge clk); #1;
        check("midreset_st", 32'(st0()), 32'h0);
        check("midreset_px", 32'(px0()), 32'h000);
        rst_n = 1'b1;
        cyc   = 0;
        run_to(20, 14'd0);
        check("post_reset_st", 32'(st0()), 32'h0);
        check("post_reset_px", 32'(px0()), 32'h59F);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/day_night_fader.md
Name: day_night_fader

Overview:
- Parametrised day/night palette fader on the VGA pixel path, placed between the sprite/background mux and the VGA output pins.
- Watches the game score. Each time the score reaches a multiple of PERIOD, it fades the palette to "night" over 2^CW ticks, holds night for DARK_LEN score points, then fades back.
- Adds over the previous generation: generic colour width, selectable transform mode, crossing-based triggering, restart detection, registered pixel path and status outputs.

Parameters:
- CW, 4: bits per colour channel; fade level range is 0..2^CW-1.
- SCORE_W, 14: game score width.
- PERIOD, 700: score interval that triggers night.
- DARK_LEN, 150: score points to stay dark after a trigger.
- TICK_W, 23: fade step occurs once every 2^TICK_W clocks.
- MODE, 0: 0 = invert-distance (|c-level|); 1 = dim (saturating c-level, floor 0).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- valid  in  1  pixel inside visible area
- game_score  in  SCORE_W  current score
- in_r  in  CW  source red
- in_g  in  CW  source green
- in_b  in  CW  source blue
- out_r  out  CW  faded red (registered)
- out_g  out  CW  faded green (registered)
- out_b  out  CW  faded blue (registered)
- is_dark  out  1  state is FADE_DARK or DARK
- fading  out  1  state is FADE_DARK or FADE_LIGHT

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=LIGHT, level=0, tick_cnt=0, start_score=0, last_score=0.
  - out_r/g/b=0, is_dark=0, fading=0.
- Tick generator:
  - tick_cnt is a free-running TICK_W-bit counter that wraps.
  - tick=1 for exactly one clk when tick_cnt is all ones.
  - level changes only on tick.
- Trigger (trig):
  - trig = (game_score != last_score) && (game_score % PERIOD == 0) && (game_score != 0).
  - last_score is updated every clk.
  - A score held at a multiple of PERIOD triggers once only.
- Restart (rst_game): game_score < last_score.
- End of night (dark_done): (game_score - start_score) >= DARK_LEN, computed at SCORE_W+1 bits with no wrap. Uses >=, so skipped score values still end the night.
- FSM (states LIGHT, FADE_DARK, DARK, FADE_LIGHT). Priority per clk: rst_game > trig > dark_done.
  - rst_game in any state -> FADE_LIGHT; if level==0 -> LIGHT.
  - trig in any state -> start_score=game_score. Next state is FADE_DARK, or DARK if level==2^CW-1. The night hold restarts.
  - FADE_DARK: on tick, level+1. Moves to DARK in the same clk that level reaches 2^CW-1.
  - DARK: on dark_done -> FADE_LIGHT.
  - FADE_DARK with dark_done: switches to FADE_LIGHT immediately; level reverses from its current value.
  - FADE_LIGHT: on tick, level-1. Moves to LIGHT when level reaches 0.
  - LIGHT: level held at 0.
  - Level saturates; it never wraps at 0 or 2^CW-1.
- Pixel path (latency exactly 1 clk):
  - out_x <= valid ? f(in_x, level) : 0.
  - MODE 0: f = in_x >= level ? in_x-level : level-in_x.
  - MODE 1: f = in_x > level ? in_x-level : 0.
  - The level used is the pre-update value in the same clk.
  - No combinational path from inputs to outputs.
- Status outputs: is_dark and fading are registered decodes of the next state. They are valid in the same clk the state register changes.
- Reset mid-fade: everything returns to reset values on the next edge. No fade resumes afterwards.

Test Plan:
- Reset and idle: rst_n=0 for 2 clk, then score 0..699, valid=1, in=(5,9,15). Expect out=(5,9,15) one clk after input; is_dark=0; level=0. During reset, out=0.
- Trigger and full fade, TICK_W=2, MODE 0: score steps to 700. Expect FADE_DARK next clk and level +1 every 4 clk. DARK reached after 15 ticks (60 clk). in=(5,9,15) gives out=(10,6,0) at level 15.
- Hold and return: from DARK, score 700->849 stays DARK. Score 850 -> FADE_LIGHT. Level reaches 0 after 15 ticks; state LIGHT; is_dark=0.
- Skipped score and single trigger: score held at 1400 for 100 clk triggers once (start_score=1400). Score jumps 1400->1600 -> dark_done -> FADE_LIGHT.
- Restart during DARK: score 760 -> 0. Expect FADE_LIGHT. Score 0 must not re-trigger.
- MODE 1 and valid gating: level 8, in=(3,12,15). Expect out=(0,4,7). valid=0 gives out=(0,0,0) one clk later.
